fmul_issue_ctrl: RTL and testbench

- Valid/ready control stage wrapped around the single-precision multiplier datapath. Accepts operand pairs with a destination tag, drives the multiplier operand ports, and captures the multiplier result exactly MUL_LAT cycles later. Results go into a small in-order result buffer with valid/ready handshake toward writeback.
- The multiplier has no enable and no stall, so this block's credit logic is the only backpressure mechanism.

---
 rtl/fmul_issue_ctrl_pkg.sv | 35 +++
 rtl/fmul_issue_ctrl_if.sv | 30 +++
 rtl/fmul_issue_ctrl_rbuf.sv | 64 ++++++
 rtl/fmul_issue_ctrl.sv | 119 +++++++++++
 tb/tb_fmul_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_issue_ctrl_pkg.sv
// Shared single-precision multiplier constants, entry types and operand classifiers.
// Flag fields exist only when FMUL_FLAGS_EN is defined.
package fpu_pkg;

    localparam int unsigned FP_W       = 32;
    localparam int unsigned EXP_W      = 8;
    localparam int unsigned MAN_W      = 23;
    localparam int unsigned FMUL_LAT   = 1;
    localparam int unsigned FMUL_TAG_W = 6;

    typedef struct packed {
        logic [FP_W-1:0]       y;
        logic [FMUL_TAG_W-1:0] tag;
`ifdef FMUL_FLAGS_EN
        logic [1:0]            flags;
`endif
    } fmul_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [FMUL_TAG_W-1:0] tag;
`ifdef FMUL_FLAGS_EN
        logic [1:0]            flags;
`endif
    } fmul_inflight_t;

    function automatic logic fp_is_denorm(input logic [FP_W-1:0] x);
        return (x[FP_W-2 -: EXP_W] == '0) && (x[MAN_W-1:0] != '0);
    endfunction

    function automatic logic fp_is_infnan(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EXP_W] == '1;
    endfunction

endpackage

// File: rtl/fmul_issue_ctrl_if.sv
// Operand-issue and result-writeback handshake bundle for fmul_issue_ctrl.
// master = producer/consumer side, slave = the issue controller.
interface fmul_issue_if
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = FMUL_TAG_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [FP_W-1:0]  in_x1;
    logic [FP_W-1:0]  in_x2;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [FP_W-1:0]  out_y;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    modport slave (
        input  in_valid, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );

endinterface

// File: rtl/fmul_issue_ctrl_rbuf.sv
// DEPTH-entry in-order result buffer (module fmul_rbuf) with push/pop/flush.
// Storage is cleared on reset so the head reads as zero until the first capture.
module fmul_rbuf
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fmul_entry_t                push_data_i,
    input  logic                       pop_i,
    output fmul_entry_t                head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    fmul_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    // Upstream credit accounting must make a capture into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push_i && !flush_i) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Valid/ready issue stage around a fixed-latency FP32 multiplier with credit backpressure.
// Optional macro FMUL_FLAGS_EN adds denormal/inf-NaN input flags carried to out_flags.
module fmul_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = FMUL_TAG_W,
    parameter int unsigned MUL_LAT = FMUL_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    fmul_issue_if.slave     bus,
    output logic [FP_W-1:0] mul_x1,
    output logic [FP_W-1:0] mul_x2,
    input  logic [FP_W-1:0] mul_y
`ifdef FMUL_FLAGS_EN
    ,
    output logic [1:0]      out_flags
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + MUL_LAT + 1);

    fmul_inflight_t             sr_q [MUL_LAT];
    fmul_inflight_t             sr_d [MUL_LAT];
    fmul_inflight_t             tail;
    fmul_entry_t                cap_ent;
    fmul_entry_t                head;
    logic                       accept;
    logic                       capture;
    logic                       pop;
    logic                       credit_ok;
    logic                       buf_valid;
    logic [$clog2(DEPTH+1)-1:0] buf_cnt;
    logic [CNT_W-1:0]           inflight_cnt;
    logic [CNT_W-1:0]           occ;

    assign mul_x1 = bus.in_x1;
    assign mul_x2 = bus.in_x2;

    assign pop          = buf_valid & bus.out_ready;
    assign bus.in_ready = ~rst & ~flush & credit_ok;
    assign accept       = bus.in_valid & bus.in_ready & ~flush;

    // Occupancy counts results still inside the multiplier; a same-cycle pop frees a slot.
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(sr_q[i].valid);
        end
        occ       = CNT_W'(buf_cnt) + inflight_cnt;
        credit_ok = (occ - CNT_W'(pop)) < CNT_W'(DEPTH);
    end

    always_comb begin
        sr_d[0]       = '0;
        sr_d[0].valid = accept;
        sr_d[0].tag   = bus.in_tag;
`ifdef FMUL_FLAGS_EN
        sr_d[0].flags = {fp_is_infnan(bus.in_x1) | fp_is_infnan(bus.in_x2),
                         fp_is_denorm(bus.in_x1) | fp_is_denorm(bus.in_x2)};
`endif
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        if (flush) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                sr_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

    assign tail    = sr_q[MUL_LAT-1];
    assign capture = tail.valid;

    always_comb begin
        cap_ent       = '0;
        cap_ent.y     = mul_y;
        cap_ent.tag   = tail.tag;
`ifdef FMUL_FLAGS_EN
        cap_ent.flags = tail.flags;
`endif
    end

    fmul_rbuf #(
        .DEPTH (DEPTH)
    ) u_rbuf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (capture),
        .push_data_i (cap_ent),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (buf_valid),
        .count_o     (buf_cnt)
    );

    assign bus.out_valid = buf_valid;
    assign bus.out_y     = head.y;
    assign bus.out_tag   = head.tag;
`ifdef FMUL_FLAGS_EN
    assign out_flags     = head.flags;
`endif

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed and random bench for fmul_issue_ctrl against a queue-based occupancy model.
// Define FMUL_FLAGS_EN for both bench and RTL to also check out_flags.
module tb_fmul_issue_ctrl;
    import fpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int TAG_W = 6;
    localparam int LAT   = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] mul_x1;
    logic [31:0] mul_x2;
    logic [31:0] mul_y;
`ifdef FMUL_FLAGS_EN
    logic [1:0]  out_flags;
`endif

    fmul_issue_if #(.TAG_W(TAG_W)) bus ();

    fmul_issue_ctrl #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .MUL_LAT (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .bus    (bus),
        .mul_x1 (mul_x1),
        .mul_x2 (mul_x2),
        .mul_y  (mul_y)
`ifdef FMUL_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: exact IEEE products for the directed operands, a scramble otherwise.
    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
            {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
            {32'h00000000, 32'h40000000}: return 32'h00000000;
            default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h9E3779B9;
        endcase
    endfunction

    always @(posedge clk) mul_y <= mul_model(mul_x1, mul_x2);

    function automatic logic [1:0] flag_model(input logic [31:0] a, input logic [31:0] b);
        logic dn;
        logic sp;
        dn = (a[30:23] == 8'd0 && a[22:0] != 23'd0) || (b[30:23] == 8'd0 && b[22:0] != 23'd0);
        sp = (a[30:23] == 8'd255) || (b[30:23] == 8'd255);
        return {sp, dn};
    endfunction

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic [1:0]       fl;
        int               acc;
    } op_t;

    op_t q[$];
    int  tests   = 0;
    int  fails   = 0;
    int  cyc     = 0;
    int  dut_acc = 0;
    bit  last_acc;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model across the edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input bit ordy, input bit fl, input bit r);
        bit  exp_ov;
        bit  exp_ir;
        bit  pop;
        op_t op;
        rst           = r;
        flush         = fl;
        bus.in_valid  = v;
        bus.in_x1     = a;
        bus.in_x2     = b;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_ov = 1'b0;
        if (q.size() != 0) exp_ov = (cyc >= q[0].acc + LAT + 1);
        pop    = exp_ov && ordy;
        exp_ir = !r && !fl && ((q.size() - int'(pop)) < DEPTH);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            check("out_y", bus.out_y, q[0].y);
            check("out_tag", 32'(bus.out_tag), 32'(q[0].tag));
`ifdef FMUL_FLAGS_EN
            check("out_flags", 32'(out_flags), 32'(q[0].fl));
`endif
        end
        if (v && bus.in_ready) dut_acc++;
        last_acc = v && exp_ir;
        if (r || fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (last_acc) begin
                op.y   = mul_model(a, b);
                op.tag = t;
                op.fl  = flag_model(a, b);
                op.acc = cyc;
                q.push_back(op);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag_n;
        int               acc0;
        bit               pend;
        bit               fl;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x1     = '0;
        bus.in_x2     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        step(1'b1, 32'h40000000, 32'h40400000, 6'd9, 1'b0, 1'b0, 1'b1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_y", bus.out_y, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        idle(1);

        // Single op.
        step(1'b1, 32'h40000000, 32'h40400000, 6'd5, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Back-to-back stream.
        acc0 = dut_acc;
        step(1'b1, 32'h3FC00000, 32'h3FC00000, 6'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hC0000000, 32'h40400000, 6'd2, 1'b1, 1'b0, 1'b0);
        check("b2b_accepts", 32'(dut_acc - acc0), 32'd2);
        idle(3);

        // Backpressure: producer holds each op until accepted.
        acc0  = dut_acc;
        tag_n = 6'd10;
        a     = $urandom;
        b     = $urandom;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, a, b, tag_n, 1'b0, 1'b0, 1'b0);
            if (last_acc) begin tag_n++; a = $urandom; b = $urandom; end
        end
        check("bp_accepts", 32'(dut_acc - acc0), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, a, b, tag_n, 1'b1, 1'b0, 1'b0);
            if (last_acc) begin tag_n++; a = $urandom; b = $urandom; end
        end
        idle(4);

        // Zero operand and flag inputs.
        step(1'b1, 32'h00000000, 32'h40000000, 6'd7, 1'b1, 1'b0, 1'b0);
`ifdef FMUL_FLAGS_EN
        step(1'b1, 32'h00000001, 32'h3F800000, 6'd40, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h7F800000, 32'h3F800000, 6'd41, 1'b1, 1'b0, 1'b0);
`endif
        idle(3);

        // Flush with one result buffered and one op in flight, in_valid high during flush.
        step(1'b1, 32'h40000000, 32'h40400000, 6'd20, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3FC00000, 32'h3FC00000, 6'd21, 1'b0, 1'b0, 1'b0);
        acc0 = dut_acc;
        step(1'b1, 32'hC0000000, 32'h40400000, 6'd22, 1'b1, 1'b1, 1'b0);
        check("flush_no_accept", 32'(dut_acc - acc0), 32'd0);
        idle(4);

        // Reset mid-stream.
        step(1'b1, 32'h12345678, 32'h3F800000, 6'd30, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h40000000, 32'h3FC00000, 6'd31, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h40400000, 32'h3FC00000, 6'd32, 1'b1, 1'b0, 1'b1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_y", bus.out_y, 32'd0);
        check("mid_rst_out_tag", 32'(bus.out_tag), 32'd0);
        step(1'b1, 32'h40000000, 32'h40400000, 6'd33, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Random traffic with rare flushes and occasional special operands.
        pend  = 1'b0;
        tag_n = 6'd0;
        a     = '0;
        b     = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                a    = $urandom;
                b    = $urandom;
                case ($urandom_range(0, 7))
                    0: a = 32'h00000001;
                    1: b = 32'h7FC00000;
                    default: ;
                endcase
            end
            fl = ($urandom_range(0, 31) == 0);
            step(pend, a, b, tag_n, ($urandom_range(0, 3) != 0), fl, 1'b0);
            if (last_acc) begin pend = 1'b0; tag_n++; end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
